// File: rtl/regfile_mp.sv
// regfile_mp: NREG x XLEN register file with NRD bypassed read ports, one write
// port, a sequenced bulk-clear engine, a button-driven debug snoop and two
// fixed watch taps for the syscall logic.
//
// state  | meaning
// -------+---------------------------------------------------------------
// IDLE   | normal operation, writes accepted, clr_req starts a clear
// CLEAR  | zeroing register cnt each edge, writes dropped, clr_req ignored
module regfile_mp #(
    parameter int XLEN    = 32,
    parameter int NREG    = 32,
    parameter int NRD     = 2,
    parameter int WATCH_A = 17,
    parameter int WATCH_B = 10,
    localparam int AW     = $clog2(NREG)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NRD*AW-1:0]   rd_addr,
    output logic [NRD*XLEN-1:0] rd_data,
    input  logic                we,
    input  logic [AW-1:0]       waddr,
    input  logic [XLEN-1:0]     wdata,
    output logic                wr_drop,
    input  logic                clr_req,
    output logic                busy,
    output logic                clr_done,
    input  logic                dbg_en,
    input  logic                dbg_btn,
    input  logic [AW-1:0]       dbg_addr,
    output logic [XLEN-1:0]     dbg_data,
    output logic                dbg_valid,
    output logic [XLEN-1:0]     watch_a,
    output logic [XLEN-1:0]     watch_b
);

    localparam logic [AW-1:0] LAST_IDX = AW'(NREG - 1);
    localparam logic [AW-1:0] WA_IDX   = AW'(WATCH_A);
    localparam logic [AW-1:0] WB_IDX   = AW'(WATCH_B);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_CLEAR = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [AW-1:0]   cnt_q, cnt_d;
    logic            clr_last;
    logic [XLEN-1:0] regs_q [NREG];
    logic            wr_drop_q, clr_done_q, dbg_valid_q, btn_prev_q;
    logic [XLEN-1:0] dbg_data_q;
    logic            wr_hit, wr_ok;
    logic [XLEN-1:0] dbg_val;

    // A write is "attempted" for any nonzero target; it only lands while idle.
    assign wr_hit = we && (waddr != '0);
    assign wr_ok  = wr_hit && (state_q == S_IDLE);

    // Clear sequencer next-state: cnt walks 1..NREG-1, register 0 is never touched.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        clr_last = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (clr_req) begin
                    state_d = S_CLEAR;
                    cnt_d   = AW'(1);
                end
            end
            S_CLEAR: begin
                cnt_d = cnt_q + AW'(1);
                if (cnt_q == LAST_IDX) begin
                    state_d  = S_IDLE;
                    clr_last = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Clear sequencer state register and status pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            clr_done_q <= 1'b0;
            wr_drop_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            clr_done_q <= clr_last;
            wr_drop_q  <= wr_hit && (state_q == S_CLEAR);
        end
    end

    // Register array: clear step and accepted write are mutually exclusive by state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
        end else if (state_q == S_CLEAR) begin
            regs_q[cnt_q] <= '0;
        end else if (wr_ok) begin
            regs_q[waddr] <= wdata;
        end
    end

    // Read ports with same-cycle write bypass; address 0 always reads zero.
    for (genvar i = 0; i < NRD; i++) begin : g_rd
        logic [AW-1:0] a;
        assign a = rd_addr[i*AW +: AW];
        assign rd_data[i*XLEN +: XLEN] = (a == '0)               ? '0    :
                                         (wr_ok && (waddr == a)) ? wdata :
                                                                   regs_q[a];
    end

    assign dbg_val = (dbg_addr == '0)               ? '0    :
                     (wr_ok && (waddr == dbg_addr)) ? wdata :
                                                      regs_q[dbg_addr];

    // Debug snoop: capture on button rising edge while enabled, clear when disabled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            btn_prev_q  <= 1'b0;
            dbg_data_q  <= '0;
            dbg_valid_q <= 1'b0;
        end else begin
            btn_prev_q <= dbg_btn;
            if (!dbg_en) begin
                dbg_data_q  <= '0;
                dbg_valid_q <= 1'b0;
            end else if (dbg_btn && !btn_prev_q) begin
                dbg_data_q  <= dbg_val;
                dbg_valid_q <= 1'b1;
            end
        end
    end

    assign busy      = (state_q == S_CLEAR);
    assign clr_done  = clr_done_q;
    assign wr_drop   = wr_drop_q;
    assign dbg_data  = dbg_data_q;
    assign dbg_valid = dbg_valid_q;
    assign watch_a   = regs_q[WA_IDX];
    assign watch_b   = regs_q[WB_IDX];

endmodule
